// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and write-back steps for a small 6-bit-opcode ISA.
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   reset        - synchronous active-low reset
//   opcode       - IR[31:26]
//   zero         - ALU zero flag (the datapath gates the branch PC write)
//   PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite, ALUSrcA, RegReadSel
//                - 1-bit datapath controls (RegReadSel: 0 = R3, 1 = R1)
//   MemtoReg, ALUSrcB, PCSource (2 bits), ALUSel (4 bits) - datapath selects
//   state        - current state encoding, for debug
//   halted       - high while in HALT
//   illegal_op   - sticky, set when an unlisted opcode is decoded
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IRWrite,
  output logic       DMEMWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       RegReadSel,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUSel,
  output logic [3:0] state,
  output logic       halted,
  output logic       illegal_op
);

  localparam logic [5:0] OpNop  = 6'h00;
  localparam logic [5:0] OpAdd  = 6'h01;
  localparam logic [5:0] OpSub  = 6'h02;
  localparam logic [5:0] OpAnd  = 6'h03;
  localparam logic [5:0] OpOr   = 6'h04;
  localparam logic [5:0] OpAddi = 6'h05;
  localparam logic [5:0] OpAndi = 6'h06;
  localparam logic [5:0] OpLli  = 6'h07;
  localparam logic [5:0] OpLui  = 6'h08;
  localparam logic [5:0] OpLwi  = 6'h09;
  localparam logic [5:0] OpSwi  = 6'h0A;
  localparam logic [5:0] OpBeq  = 6'h0B;
  localparam logic [5:0] OpJmp  = 6'h0C;
  localparam logic [5:0] OpHalt = 6'h3F;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExecR  = 4'd2,
    StExecI  = 4'd3,
    StAluWb  = 4'd4,
    StImmWb  = 4'd5,
    StMemRd  = 4'd6,
    StMemWb  = 4'd7,
    StMemWr  = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StHalt   = 4'd11
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  // The branch condition is applied by the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = StFetch;
    illegal_d   = illegal_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    DMEMWrite   = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    MemtoReg    = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUSel      = 4'b0000;
    halted      = 1'b0;

    // Immediate-load, store and branch read R1 instead of R3. In FETCH the IR
    // is still being loaded, so the selector is held at 0 there.
    RegReadSel = (state_q != StFetch) &&
                 ((opcode == OpLli) || (opcode == OpLui) ||
                  (opcode == OpSwi) || (opcode == OpBeq));

    case (state_q)
      StFetch: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        state_d = StDecode;
      end
      StDecode: begin
        case (opcode)
          OpAdd, OpSub, OpAnd, OpOr: state_d = StExecR;
          OpAddi, OpAndi:            state_d = StExecI;
          OpLli, OpLui:              state_d = StImmWb;
          OpLwi:                     state_d = StMemRd;
          OpSwi:                     state_d = StMemWr;
          OpBeq:                     state_d = StBranch;
          OpJmp:                     state_d = StJump;
          OpHalt:                    state_d = StHalt;
          OpNop:                     state_d = StFetch;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StExecR: begin
        ALUSrcA = 1'b1;
        case (opcode)
          OpSub:   ALUSel = 4'b0001;
          OpAnd:   ALUSel = 4'b0010;
          OpOr:    ALUSel = 4'b0011;
          default: ALUSel = 4'b0000;
        endcase
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = 1'b1;
        if (opcode == OpAndi) begin
          ALUSrcB = 2'b11;
          ALUSel  = 4'b0010;
        end else begin
          ALUSrcB = 2'b10;
        end
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StImmWb: begin
        RegWrite = 1'b1;
        MemtoReg = (opcode == OpLui) ? 2'b11 : 2'b10;
        state_d  = StFetch;
      end
      StMemRd: begin
        // MDR captures DMem[imm] this cycle.
        state_d = StMemWb;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
        state_d  = StFetch;
      end
      StMemWr: begin
        DMEMWrite = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUSel      = 4'b0001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b10;
        state_d     = StFetch;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = StFetch;
      end
      StHalt: begin
        halted  = 1'b1;
        state_d = StHalt;
      end
      default: state_d = StFetch;
    endcase
  end

  assign state      = state_q;
  assign illegal_op = illegal_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-003 SHALL have port opcode, input, 6 bits: the instruction register's bits [31:26].
REQ-004 SHALL have port zero, input, 1 bit: the main ALU zero flag.
REQ-005 SHALL have outputs PCWrite, PCWriteCond, IRWrite, DMEMWrite, RegWrite, ALUSrcA and RegReadSel, 1 bit each, meaning as on the datapath. RegReadSel: 0 selects R3, 1 selects R1.
REQ-006 SHALL have outputs MemtoReg, ALUSrcB and PCSource, 2 bits each, and ALUSel, 4 bits, meaning as on the datapath.
REQ-007 SHALL have output state, 4 bits: the current state encoding, for debug.
REQ-008 SHALL have output halted, 1 bit: high while in HALT.
REQ-009 SHALL have output illegal_op, 1 bit: sticky flag set on decode of an unlisted opcode.

Function
REQ-010 SHALL be a Moore FSM with states FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, IMM_WB=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, BRANCH=9, JUMP=10, HALT=11. Encodings 12-15 SHALL go to FETCH on the next edge.
REQ-011 SHALL drive every output to 0 in every state unless a requirement below asserts it.
REQ-012 SHALL use this opcode map; any other opcode SHALL act as a NOP:
- 00 NOP
- 01 ADD, 02 SUB, 03 AND, 04 OR (ALUSel 0000, 0001, 0010, 0011)
- 05 ADDI, 06 ANDI
- 07 LLI, 08 LUI
- 09 LWI, 0A SWI
- 0B BEQ, 0C JMP
- 3F HALT
REQ-013 SHALL, in FETCH, assert IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUSel=0000 and PCSource=00, so that IR gets IMem[PC] and PC gets PC+1. Next state SHALL be DECODE.
REQ-014 SHALL, in every state except FETCH, drive RegReadSel=1 for opcodes 07, 08, 0A and 0B, and 0 otherwise.
REQ-015 SHALL branch from DECODE by opcode:
- R-type to EXEC_R
- 05/06 to EXEC_I
- 07/08 to IMM_WB
- 09 to MEM_RD
- 0A to MEM_WR
- 0B to BRANCH
- 0C to JUMP
- 3F to HALT
- NOP/illegal to FETCH
REQ-016 SHALL, in EXEC_R, drive ALUSrcA=1, ALUSrcB=00 and ALUSel per opcode. EXEC_I SHALL drive ALUSrcA=1 with ALUSrcB=10/ALUSel=0000 for ADDI, or ALUSrcB=11/ALUSel=0010 for ANDI. Both states SHALL go next to ALU_WB.
REQ-017 SHALL, in ALU_WB, assert RegWrite=1 with MemtoReg=00, then go to FETCH.
REQ-018 SHALL, in IMM_WB, assert RegWrite=1 with MemtoReg=10 (LLI) or 11 (LUI), then go to FETCH.
REQ-019 SHALL go from MEM_RD to MEM_WB with no outputs asserted, while the MDR captures DMem[imm]. MEM_WB SHALL assert RegWrite=1 with MemtoReg=01, then go to FETCH.
REQ-020 SHALL, in MEM_WR, assert DMEMWrite=1, then go to FETCH.
REQ-021 SHALL, in BRANCH, drive ALUSrcA=1, ALUSrcB=00, ALUSel=0001, PCWriteCond=1 and PCSource=10, then go to FETCH. The PC update is conditional on zero, which the datapath gates.
REQ-022 SHALL, in JUMP, assert PCWrite=1 with PCSource=10, then go to FETCH.
REQ-023 SHALL remain in HALT with halted=1 and all write enables 0 until reset.
REQ-024 SHALL take these cycles per instruction, counted from FETCH:
- NOP/illegal: 2
- LLI/LUI, SWI, BEQ, JMP: 3
- R-type, ADDI/ANDI, LWI: 4
REQ-025 SHALL set illegal_op on the DECODE edge of an unlisted opcode; only reset SHALL clear it.
REQ-026 SHALL never assert more than one of RegWrite, DMEMWrite or IRWrite in the same cycle.

Reset
REQ-027 SHALL, with reset=0 at a rising edge, set state=FETCH and illegal_op=0 regardless of the current state, including mid-instruction and HALT.
REQ-028 SHALL, while held in reset, present FETCH outputs combinationally after the first edge. FETCH writes SHALL be harmless because the datapath registers share the same reset.
REQ-029 SHALL, after reset deasserts, enter DECODE on the first rising edge.

Verification
REQ-030 SHALL cover: opcode=01 after reset -> states 0,1,2,4,0; RegWrite=1 only in state 4, with ALUSel=0000 in state 2.
REQ-031 SHALL cover: opcode=0B with zero=1, then with zero=0 -> both pass through state 9 with PCWriteCond=1 and PCSource=10, 3 cycles each.
REQ-032 SHALL cover: opcode=09 -> states 0,1,6,7,0; MemtoReg=01 and RegWrite=1 only in state 7; opcode=0A -> DMEMWrite=1 exactly one cycle, in state 8.
REQ-033 SHALL cover: opcode=3F -> HALT, halted=1 for 20 or more cycles; then reset=0 for one edge -> state=0, halted=0.
REQ-034 SHALL cover: opcode=2A -> illegal_op=1 after DECODE, 2-cycle NOP, flag still 1 after 10 further instructions, cleared only by reset.
REQ-035 SHALL cover: reset=0 asserted in state 7 -> the next state is 0 and RegWrite deasserts on that edge.
